mdio_transaction_engine: RTL and testbench

MDIO_TRANSACTION_ENGINE -- requirements
Module: mdio_transaction_engine

---
 rtl/mdio_transaction_engine.sv | 171 +++++++++++++++++
 tb/tb_mdio_transaction_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_transaction_engine.sv
// -----------------------------------------------------------------------------
// mdio_transaction_engine
//
// Clause-22 style MDIO management master. One read or write request launches
// a full 64-bit frame: 32 preamble ones, a 14-bit header (ST, OP, PHYAD,
// REGAD), a 2-bit turnaround and 16 data bits. MDC is derived from clk by
// dividing with CLK_DIV, so every bit lasts 2*CLK_DIV clk cycles. MDC is low
// for the first half of the bit and high for the second half.
//
// Parameters
//   CLK_DIV       MDC half-period in clk cycles (2..255)
//
// Ports
//   clk           core clock, all logic on its rising edge
//   rst           synchronous active-high reset
//   phy_md_addr   PHY address, captured with the request
//   phy_reg_addr  register address, captured with the request
//   phy_wr_data   write data, captured with the request
//   phy_reg_wr    single-cycle write request (wins over a simultaneous read)
//   phy_reg_rd    single-cycle read request
//   phy_rd_data   result of the last completed read
//   mdio_busy     high while a frame is on the wire
//   mdc           MDIO management clock
//   mdio_out      MDIO data driven by the engine
//   mdio_oe       MDIO output enable, 1 = drive
//   mdio_in       MDIO pad input, already synchronized to clk
// -----------------------------------------------------------------------------
module mdio_transaction_engine #(
  parameter int CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  phy_md_addr,
  input  logic [4:0]  phy_reg_addr,
  input  logic [15:0] phy_wr_data,
  input  logic        phy_reg_wr,
  input  logic        phy_reg_rd,
  output logic [15:0] phy_rd_data,
  output logic        mdio_busy,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  input  logic        mdio_in
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    TURNAROUND,
    DATA
  } state_t;

  // Last value of the divider within one MDC half-period.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  // Index of the last bit of each frame section (bits numbered 0..63).
  localparam logic [5:0] LAST_PRE  = 6'd31;
  localparam logic [5:0] LAST_HDR  = 6'd45;
  localparam logic [5:0] LAST_TA   = 6'd47;
  localparam logic [5:0] LAST_BIT  = 6'd63;

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic        is_read;
  logic [62:0] tx_shift;
  logic [15:0] rx_shift;

  logic        request;
  logic [1:0]  req_op;
  logic [1:0]  req_ta;
  logic [15:0] req_data;
  logic [62:0] frame_tail;

  // Bit 0 of the frame (a preamble one) goes out directly on the request
  // edge, so the shift register only needs to hold bits 1..63. For reads the
  // turnaround and data positions are filled with ones; they are never driven
  // because the output enable is dropped for those bits.
  always_comb begin
    request    = phy_reg_wr | phy_reg_rd;
    req_op     = phy_reg_wr ? 2'b01 : 2'b10;
    req_ta     = phy_reg_wr ? 2'b10 : 2'b11;
    req_data   = phy_reg_wr ? phy_wr_data : 16'hFFFF;
    frame_tail = {31'h7FFF_FFFF, 2'b01, req_op, phy_md_addr, phy_reg_addr,
                  req_ta, req_data};
  end

  // Frame sequencer. The divider counts clk cycles inside each MDC half;
  // at the end of the low half MDC rises and read data is sampled, at the
  // end of the high half MDC falls and the next bit is presented, so data
  // and enable only ever change together with the falling MDC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mdio_busy   <= 1'b0;
      mdc         <= 1'b0;
      mdio_oe     <= 1'b0;
      mdio_out    <= 1'b1;
      phy_rd_data <= 16'h0000;
      bit_cnt     <= 6'd0;
      div_cnt     <= 8'd0;
      is_read     <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            state     <= PREAMBLE;
            mdio_busy <= 1'b1;
            mdc       <= 1'b0;
            mdio_oe   <= 1'b1;
            mdio_out  <= 1'b1;
            is_read   <= ~phy_reg_wr;
            tx_shift  <= frame_tail;
            rx_shift  <= 16'h0000;
            bit_cnt   <= 6'd0;
            div_cnt   <= 8'd0;
          end
        end

        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!mdc) begin
              mdc <= 1'b1;
              // Turnaround bits are deliberately not captured.
              if (state == DATA && is_read) begin
                rx_shift <= {rx_shift[14:0], mdio_in};
              end
            end else begin
              mdc <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                state     <= IDLE;
                mdio_busy <= 1'b0;
                mdio_oe   <= 1'b0;
                mdio_out  <= 1'b1;
                bit_cnt   <= 6'd0;
                if (is_read) begin
                  phy_rd_data <= rx_shift;
                end
              end else begin
                bit_cnt  <= bit_cnt + 6'd1;
                tx_shift <= {tx_shift[61:0], 1'b1};
                // From bit 46 onward a read releases the line to the PHY.
                if (is_read && bit_cnt >= LAST_HDR) begin
                  mdio_oe  <= 1'b0;
                  mdio_out <= 1'b1;
                end else begin
                  mdio_oe  <= 1'b1;
                  mdio_out <= tx_shift[62];
                end
                if (bit_cnt == LAST_PRE) begin
                  state <= HEADER;
                end else if (bit_cnt == LAST_HDR) begin
                  state <= TURNAROUND;
                end else if (bit_cnt == LAST_TA) begin
                  state <= DATA;
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_transaction_engine.sv
// -----------------------------------------------------------------------------
// tb_mdio_transaction_engine
//
// Instance A runs with CLK_DIV=4 and carries the write, read, collision, busy
// and reset scenarios; instance B runs with CLK_DIV=2 for back-to-back frames.
// A small PHY model per instance answers reads with a preset 16-bit word.
// Expected wire bits and frame completions are queued when a request is
// issued; negedge monitors pop and compare as the engine produces them.
// -----------------------------------------------------------------------------
module tb_mdio_transaction_engine;

  typedef struct packed {
    logic drv;
    logic en;
  } bit_exp_t;

  typedef struct {
    int          done_cyc;
    logic [15:0] rd;
  } frame_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  // Instance A signals
  logic [4:0]  phy_a = '0, reg_a = '0;
  logic [15:0] wdata_a = '0, rdata_a;
  logic        wr_a = 1'b0, rd_a = 1'b0;
  logic        busy_a, mdc_a, out_a, oe_a;
  logic        in_a = 1'b1;
  logic [15:0] resp_a = '0;

  // Instance B signals
  logic [4:0]  phy_b = '0, reg_b = '0;
  logic [15:0] wdata_b = '0, rdata_b;
  logic        wr_b = 1'b0, rd_b = 1'b0;
  logic        busy_b, mdc_b, out_b, oe_b;
  logic        in_b = 1'b1;
  logic [15:0] resp_b = '0;

  bit_exp_t   bitq_a[$];
  frame_exp_t frameq_a[$];
  frame_exp_t frameq_b[$];
  bit         abort_a = 1'b0;

  localparam logic [63:0] OE_WRITE = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] OE_READ  = 64'hFFFF_FFFF_FFFC_0000;

  mdio_transaction_engine #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst),
    .phy_md_addr(phy_a), .phy_reg_addr(reg_a), .phy_wr_data(wdata_a),
    .phy_reg_wr(wr_a), .phy_reg_rd(rd_a), .phy_rd_data(rdata_a),
    .mdio_busy(busy_a), .mdc(mdc_a), .mdio_out(out_a), .mdio_oe(oe_a),
    .mdio_in(in_a)
  );

  mdio_transaction_engine #(.CLK_DIV(2)) dut_b (
    .clk(clk), .rst(rst),
    .phy_md_addr(phy_b), .phy_reg_addr(reg_b), .phy_wr_data(wdata_b),
    .phy_reg_wr(wr_b), .phy_reg_rd(rd_b), .phy_rd_data(rdata_b),
    .mdio_busy(busy_b), .mdc(mdc_b), .mdio_out(out_b), .mdio_oe(oe_b),
    .mdio_in(in_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Queue the 64 wire bits (MSB first) and the completion of one A frame.
  task automatic expectFrameA(input logic [63:0] bits, input logic [63:0] oes,
                              input int latency, input logic [15:0] rd);
    frame_exp_t f;
    for (int i = 63; i >= 0; i--) begin
      bit_exp_t e;
      e.drv = bits[i];
      e.en  = oes[i];
      bitq_a.push_back(e);
    end
    f.done_cyc = cyc + latency;
    f.rd       = rd;
    frameq_a.push_back(f);
  endtask

  task automatic expectFrameB(input int latency, input logic [15:0] rd);
    frame_exp_t f;
    f.done_cyc = cyc + latency;
    f.rd       = rd;
    frameq_b.push_back(f);
  endtask

  // Holds a request for one cycle; called and returns at posedge+1.
  task automatic applyStimulus(input bit sel_b, input logic wr, input logic rd,
                               input logic [4:0] phy, input logic [4:0] ra,
                               input logic [15:0] wd);
    if (!sel_b) begin
      wr_a = wr; rd_a = rd; phy_a = phy; reg_a = ra; wdata_a = wd;
    end else begin
      wr_b = wr; rd_b = rd; phy_b = phy; reg_b = ra; wdata_b = wd;
    end
    @(posedge clk); #1;
    wr_a = 1'b0; rd_a = 1'b0; wr_b = 1'b0; rd_b = 1'b0;
  endtask

  task automatic waitIdle(input bit sel_b, input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((sel_b ? busy_b : busy_a) && n < budget);
    checkOutput(sel_b ? "wait_idle_b" : "wait_idle_a",
                sel_b ? busy_b : busy_a, 0);
  endtask

  // Instance A: PHY model, wire-bit monitor and frame-completion monitor.
  logic     pb_a = 1'b0, pm_a = 1'b0;
  bit_exp_t cur_a;
  bit       have_cur_a = 1'b0;
  int       phy_bit_a = 0;

  always @(negedge clk) begin
    if (busy_a && !mdc_a && (!pb_a || pm_a)) begin
      if (!pb_a) phy_bit_a = 0;
      else       phy_bit_a++;
      if (phy_bit_a >= 48) in_a = resp_a[63 - phy_bit_a];
      else                 in_a = 1'b1;
    end
    if (mdc_a && !pm_a) begin
      checkOutput("bit_expected", bitq_a.size() != 0, 1);
      if (bitq_a.size() != 0) begin
        cur_a      = bitq_a.pop_front();
        have_cur_a = 1'b1;
      end
    end
    if (mdc_a && have_cur_a) begin
      checkOutput("mdio_out", out_a, cur_a.drv);
      checkOutput("mdio_oe", oe_a, cur_a.en);
    end
    if (!mdc_a) have_cur_a = 1'b0;
    if (pb_a && !busy_a) begin
      if (abort_a) begin
        abort_a = 1'b0;
      end else begin
        checkOutput("frame_expected", frameq_a.size() != 0, 1);
        if (frameq_a.size() != 0) begin
          frame_exp_t f;
          f = frameq_a.pop_front();
          checkOutput("busy_fall_cycle", cyc, f.done_cyc);
          checkOutput("phy_rd_data", rdata_a, f.rd);
          checkOutput("idle_mdc", mdc_a, 0);
          checkOutput("idle_oe", oe_a, 0);
          checkOutput("idle_out", out_a, 1);
        end
      end
    end
    pb_a = busy_a;
    pm_a = mdc_a;
  end

  // Instance B: PHY model, MDC period monitor and frame-completion monitor.
  logic pb_b = 1'b0, pm_b = 1'b0;
  int   phy_bit_b = 0;
  int   last_rise_b = 0;
  bit   have_rise_b = 1'b0;

  always @(negedge clk) begin
    if (busy_b && !mdc_b && (!pb_b || pm_b)) begin
      if (!pb_b) phy_bit_b = 0;
      else       phy_bit_b++;
      if (phy_bit_b >= 48) in_b = resp_b[63 - phy_bit_b];
      else                 in_b = 1'b1;
    end
    if (busy_b && mdc_b && !pm_b) begin
      if (have_rise_b) checkOutput("mdc_period_b", cyc - last_rise_b, 4);
      last_rise_b = cyc;
      have_rise_b = 1'b1;
    end
    if (pb_b && !busy_b) begin
      have_rise_b = 1'b0;
      checkOutput("frame_expected_b", frameq_b.size() != 0, 1);
      if (frameq_b.size() != 0) begin
        frame_exp_t f;
        f = frameq_b.pop_front();
        checkOutput("busy_fall_cycle_b", cyc, f.done_cyc);
        checkOutput("phy_rd_data_b", rdata_b, f.rd);
      end
    end
    pb_b = busy_b;
    pm_b = mdc_b;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy_a, 0);
    checkOutput("reset_mdc", mdc_a, 0);
    checkOutput("reset_oe", oe_a, 0);
    checkOutput("reset_out", out_a, 1);
    checkOutput("reset_rd_data", rdata_a, 16'h0000);
    checkOutput("reset_busy_b", busy_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write PHY 5, reg 0x1F, data 0xA5C3
    expectFrameA(64'hFFFF_FFFF_52FE_A5C3, OE_WRITE, 513, 16'h0000);
    applyStimulus(0, 1'b1, 1'b0, 5'd5, 5'h1F, 16'hA5C3);
    waitIdle(0, 600);

    // Read PHY 1, reg 0x02, PHY answers 0x1234
    resp_a = 16'h1234;
    expectFrameA(64'hFFFF_FFFF_608B_FFFF, OE_READ, 513, 16'h1234);
    applyStimulus(0, 1'b0, 1'b1, 5'd1, 5'h02, 16'h0000);
    waitIdle(0, 600);

    // Write and read together: write PHY 0x1A reg 0x05 data 0x0F0F
    expectFrameA(64'hFFFF_FFFF_5D16_0F0F, OE_WRITE, 513, 16'h1234);
    applyStimulus(0, 1'b1, 1'b1, 5'h1A, 5'h05, 16'h0F0F);
    waitIdle(0, 600);

    // Read PHY 3 reg 0x10 with a stray read mid-frame, then a read on the
    // first idle cycle (PHY 2 reg 0x11)
    resp_a = 16'hBEEF;
    expectFrameA(64'hFFFF_FFFF_61C3_FFFF, OE_READ, 513, 16'hBEEF);
    applyStimulus(0, 1'b0, 1'b1, 5'd3, 5'h10, 16'h0000);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("busy_mid_frame", busy_a, 1);
    checkOutput("rd_data_hold_mid_read", rdata_a, 16'h1234);
    applyStimulus(0, 1'b0, 1'b1, 5'd7, 5'h07, 16'h0000);
    waitIdle(0, 600);
    resp_a = 16'hC0DE;
    expectFrameA(64'hFFFF_FFFF_6147_FFFF, OE_READ, 513, 16'hC0DE);
    applyStimulus(0, 1'b0, 1'b1, 5'd2, 5'h11, 16'h0000);
    waitIdle(0, 600);

    // Reset during the preamble of a read (PHY 4 reg 3); a write strobe
    // held with reset must be ignored.
    resp_a = 16'h7777;
    expectFrameA(64'hFFFF_FFFF_620F_FFFF, OE_READ, 513, 16'h7777);
    applyStimulus(0, 1'b0, 1'b1, 5'd4, 5'h03, 16'h0000);
    repeat (40) @(posedge clk);
    #1;
    abort_a = 1'b1;
    bitq_a.delete();
    frameq_a.delete();
    rst  = 1'b1;
    wr_a = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_mdc", mdc_a, 0);
    checkOutput("abort_oe", oe_a, 0);
    checkOutput("abort_out", out_a, 1);
    checkOutput("abort_rd_data", rdata_a, 16'h0000);
    rst  = 1'b0;
    wr_a = 1'b0;
    @(posedge clk); #1;
    checkOutput("req_in_reset_ignored", busy_a, 0);
    expectFrameA(64'hFFFF_FFFF_58AA_5A5A, OE_WRITE, 513, 16'h0000);
    applyStimulus(0, 1'b1, 1'b0, 5'h11, 5'h0A, 16'h5A5A);
    waitIdle(0, 600);

    // CLK_DIV=2: back-to-back write then read
    expectFrameB(257, 16'h0000);
    applyStimulus(1, 1'b1, 1'b0, 5'd1, 5'd1, 16'h1111);
    waitIdle(1, 300);
    resp_b = 16'h8001;
    expectFrameB(257, 16'h8001);
    applyStimulus(1, 1'b0, 1'b1, 5'd1, 5'd1, 16'h0000);
    waitIdle(1, 300);

    repeat (5) @(posedge clk);
    #1;
    checkOutput("bits_left_a", bitq_a.size(), 0);
    checkOutput("frames_left_a", frameq_a.size(), 0);
    checkOutput("frames_left_b", frameq_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
